// File: rtl/reg_pkg.sv
// Shared definitions for the paired-register unloader: FSM state encodings.
package reg_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND_A  = 2'd1,
    ST_SEND_B  = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_e;
endpackage

// File: rtl/pair_hold_reg.sv
// Two-word hold register with synchronous reset and a shared load enable.
module pair_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d1,
  input  logic [WIDTH-1:0] i_d2,
  output logic [WIDTH-1:0] o_q1,
  output logic [WIDTH-1:0] o_q2
);
  logic [WIDTH-1:0] r_q1, r_q2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q1 <= '0;
      r_q2 <= '0;
    end else if (i_load) begin
      r_q1 <= i_d1;
      r_q2 <= i_d2;
    end
  end

  assign o_q1 = r_q1;
  assign o_q2 = r_q2;
endmodule

// File: rtl/reg_pair_unloader.sv
// Accepts one (D1,D2) pair per handshake and streams it out as two words, the
// second flagged LAST; refills from SEND_B without a bubble.
module reg_pair_unloader
  import reg_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter bit SECOND_FIRST = 1'b0,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_d1,
  input  logic [WIDTH-1:0] in_d2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] pair_cnt
);
  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_q1, w_q2, w_first, w_second, w_word;
  logic             w_in_ready, w_out_valid, w_out_last, w_in_hs;

  pair_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_in_hs),
    .i_d1   (in_d1),
    .i_d2   (in_d2),
    .o_q1   (w_q1),
    .o_q2   (w_q2)
  );

  assign w_first  = SECOND_FIRST ? w_q2 : w_q1;
  assign w_second = SECOND_FIRST ? w_q1 : w_q2;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // in_ready in SEND_B follows out_ready so a new pair can load as the LAST word leaves.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_out_last  = 1'b0;
    w_word      = '0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) w_state_nxt = ST_SEND_A;
      end
      ST_SEND_A: begin
        w_out_valid = 1'b1;
        w_word      = w_first;
        if (out_ready) w_state_nxt = ST_SEND_B;
      end
      ST_SEND_B: begin
        w_out_valid = 1'b1;
        w_out_last  = 1'b1;
        w_word      = w_second;
        w_in_ready  = out_ready;
        if (out_ready) w_state_nxt = in_valid ? ST_SEND_A : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (rst) begin
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      w_out_last  = 1'b0;
      w_word      = '0;
    end
  end

  assign w_in_hs = in_valid & w_in_ready;

  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= '0;
    else if (w_out_valid && out_ready && r_state == ST_SEND_B)
      r_cnt <= r_cnt + CNT_W'(1);
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_last  = w_out_last;
  assign out_data  = w_word;
  assign busy      = !rst && (r_state != ST_IDLE);
  assign pair_cnt  = r_cnt;
endmodule

// File: tb/tb_reg_pair_unloader.sv
// Bench for reg_pair_unloader: two instances (D1-first/16-bit count and
// D2-first/2-bit count) share stimulus and are checked against a word-queue model.
module tb_reg_pair_unloader;
  logic       clk = 1'b0;
  logic       rst, in_valid, out_ready;
  logic [7:0] in_d1, in_d2;

  logic        ir0, ov0, ol0, b0, ir1, ov1, ol1, b1;
  logic [7:0]  od0, od1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  typedef struct packed { logic [7:0] d; logic l; } wrd_t;
  wrd_t        q0[$], q1[$];
  int unsigned cnt_m[2];
  int          nchk = 0, npass = 0;

  always #5 clk = ~clk;

  reg_pair_unloader #(.WIDTH(8), .SECOND_FIRST(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in_d1(in_d1), .in_d2(in_d2),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_last(ol0), .busy(b0), .pair_cnt(cnt0));

  reg_pair_unloader #(.WIDTH(8), .SECOND_FIRST(1'b1), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_d1(in_d1), .in_d2(in_d2),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_last(ol1), .busy(b1), .pair_cnt(cnt1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Expected behaviour: block holds at most one pair (two pending words);
  // it accepts when nothing is pending, or when the final pending word leaves now.
  task automatic chk_dut(input int k, input logic ov, input logic ir, input logic b,
                         input logic [7:0] od, input logic ol, input logic [15:0] cnt);
    int   sz;
    wrd_t fr;
    string p;
    p  = $sformatf("d%0d.", k);
    sz = (k == 0) ? q0.size() : q1.size();
    fr = '0;
    if (sz > 0) fr = (k == 0) ? q0[0] : q1[0];
    chk({p, "out_valid"}, {31'd0, ov}, {31'd0, !rst && sz > 0});
    chk({p, "in_ready"},  {31'd0, ir}, {31'd0, !rst && (sz == 0 || (sz == 1 && out_ready))});
    chk({p, "busy"},      {31'd0, b},  {31'd0, !rst && sz > 0});
    chk({p, "pair_cnt"},  {16'd0, cnt}, cnt_m[k]);
    if (rst) begin
      chk({p, "rst_data"}, {24'd0, od}, 32'd0);
      chk({p, "rst_last"}, {31'd0, ol}, 32'd0);
    end else if (sz > 0) begin
      chk({p, "out_data"}, {24'd0, od}, {24'd0, fr.d});
      chk({p, "out_last"}, {31'd0, ol}, {31'd0, fr.l});
    end
  endtask

  task automatic model_edge();
    int   sz;
    bit   rdy;
    wrd_t w;
    if (rst) begin
      q0.delete(); q1.delete();
      cnt_m[0] = 0; cnt_m[1] = 0;
    end else begin
      sz  = q0.size();
      rdy = (sz == 0) || (sz == 1 && out_ready);
      if (sz > 0 && out_ready) begin
        w = q0.pop_front(); if (w.l) cnt_m[0] = (cnt_m[0] + 1) % 65536;
        w = q1.pop_front(); if (w.l) cnt_m[1] = (cnt_m[1] + 1) % 4;
      end
      if (in_valid && rdy) begin
        q0.push_back(wrd_t'({in_d1, 1'b0})); q0.push_back(wrd_t'({in_d2, 1'b1}));
        q1.push_back(wrd_t'({in_d2, 1'b0})); q1.push_back(wrd_t'({in_d1, 1'b1}));
      end
    end
  endtask

  bit first_reset = 1'b1;

  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic ordy, input logic r);
    rst = r; in_valid = v; in_d1 = a; in_d2 = b; out_ready = ordy;
    @(negedge clk);
    if (!first_reset) begin
      chk_dut(0, ov0, ir0, b0, od0, ol0, cnt0);
      chk_dut(1, ov1, ir1, b1, od1, ol1, {14'd0, cnt1});
    end else begin
      chk("d0.rst_out_valid", {31'd0, ov0}, 32'd0);
      chk("d0.rst_in_ready",  {31'd0, ir0}, 32'd0);
    end
    @(posedge clk);
    model_edge();
    if (r) first_reset = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_d1 = '0; in_d2 = '0; out_ready = 1'b0;
    @(posedge clk); #1;

    // 1: reset with in_valid high
    step(1, 8'h12, 8'h34, 0, 1);
    step(1, 8'h12, 8'h34, 0, 1);
    chk("t1.pair_cnt", {16'd0, cnt0}, 32'd0);

    // 2: single pair
    step(1, 8'hA5, 8'h3C, 1, 0);
    chk("t2.first", {24'd0, od0, ov0, ol0}, {24'd0, 8'hA5, 1'b1, 1'b0});
    step(0, 8'h00, 8'h00, 1, 0);
    chk("t2.second", {24'd0, od0, ov0, ol0}, {24'd0, 8'h3C, 1'b1, 1'b1});
    step(0, 8'h00, 8'h00, 1, 0);
    step(0, 8'h00, 8'h00, 1, 0);
    chk("t2.pair_cnt", {16'd0, cnt0}, 32'd1);

    // 3: back-to-back pairs, no bubble
    step(0, 8'h00, 8'h00, 1, 1);
    step(1, 8'h11, 8'h22, 1, 0);
    step(1, 8'h33, 8'h44, 1, 0);
    step(1, 8'h33, 8'h44, 1, 0);
    step(1, 8'h55, 8'h66, 1, 0);
    step(1, 8'h55, 8'h66, 1, 0);
    step(0, 8'h00, 8'h00, 1, 0);
    step(0, 8'h00, 8'h00, 1, 0);
    chk("t3.pair_cnt", {16'd0, cnt0}, 32'd3);

    // 4: backpressure in both halves, new inputs ignored
    step(0, 8'h00, 8'h00, 1, 1);
    step(1, 8'hAA, 8'hBB, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 8'($urandom), 8'($urandom), 0, 0);
    chk("t4.hold_a", {24'd0, od0}, {24'd0, 8'hAA});
    step(1, 8'hC1, 8'hC2, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 8'($urandom), 8'($urandom), 0, 0);
    chk("t4.hold_b", {24'd0, od0, ol0, ir0}, {24'd0, 8'hBB, 1'b1, 1'b0});

    // 5: reset while in SEND_B
    step(1, 8'h77, 8'h88, 1, 1);
    step(0, 8'h00, 8'h00, 1, 0);
    chk("t5.after_rst", {16'd0, cnt0}, 32'd0);
    chk("t5.busy", {31'd0, b0}, 32'd0);

    // 6: five pairs; D2-first instance wraps its 2-bit count to 1
    step(0, 8'h00, 8'h00, 1, 1);
    for (int i = 0; i < 9; i++) step(1, 8'h01, 8'h02, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 8'h00, 1, 0);
    chk("t6.cnt_wrap", {30'd0, cnt1}, 32'd1);
    chk("t6.cnt_wide", {16'd0, cnt0}, 32'd5);

    // randomized traffic with occasional reset
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) < 6, 8'($urandom), 8'($urandom),
           $urandom_range(0, 9) < 7, $urandom_range(0, 99) == 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
